spj_hand_loader: RTL
====================

# spj_hand_loader

Sequential front end for the Simplified Pineapple Poker judge. It accepts one 6-bit card per cycle over a valid/ready stream and assembles the 13 cards into the front, mid and back rows. It then presents all 13 cards in parallel, together with a hand-level duplicate flag, to the combinational judge over a valid/ready handshake. The judge scores the hand from the row buses.

## Interface
- NUM_CARDS, 13, cards per hand. This is fixed and must not be overridden.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_card is valid this cycle.
- in_card  in  6  card code: [5:4] suit, [3:0] rank (0..12 legal).
- in_ready  out  1  loader can accept a card.
- out_front1..3  out  6 each  front row, in arrival order.
- out_mid1..5  out  6 each  mid row, in arrival order.
- out_back1..5  out  6 each  back row, in arrival order.
- out_dup  out  1  some card code appeared more than once in the hand.
- out_valid  out  1  hand complete; all out_* buses are stable.
- out_ready  in  1  downstream judge takes the hand.
- card_cnt  out  4  number of cards accepted so far (0..13).

## Operation
- An accept occurs on a cycle where in_valid && in_ready.
- The k-th accepted card (k = 0..12) goes to:
  - k 0..2: front1..3
  - k 3..7: mid1..5
  - k 8..12: back1..5
- FSM states:
  - IDLE: card_cnt = 0, in_ready = 1, out_valid = 0. An accept moves to LOAD.
  - LOAD: card_cnt = 1..12, in_ready = 1, out_valid = 0. The accept that makes card_cnt 13 moves to HOLD.
  - HOLD: card_cnt = 13, in_ready = 0, out_valid = 1. On out_valid && out_ready, move to IDLE.
- In HOLD, in_valid is ignored and no register changes except on handoff.
- Duplicate tracking:
  - A 64-bit seen bitmap is indexed by the full 6-bit code.
  - Each accept sets the bit for its code.
  - out_dup sets (sticky) if that bit was already 1 at the time of the accept.
- Handoff (HOLD to IDLE) clears the bitmap, out_dup and card_cnt. Row registers keep their old values until overwritten by the next hand.
- Rank range (>12), cross-row ordering and scoring are not checked here; the judge owns them. Duplicates within a row are also flagged by the judge. out_dup is the only check that spans rows.
- in_card with in_valid low is don't-care and must not be written.

## Timing
- Reset (rst = 1 at a clock edge):
  - state IDLE; card_cnt 0; every out_* row bus 6'd0; out_dup 0; out_valid 0; bitmap cleared.
  - in_ready reads 1 from the first cycle after reset.
- Reset asserted mid-load or in HOLD discards the partial or pending hand with no handoff. A card presented in the reset cycle is not accepted.
- in_ready and out_valid are decoded from registered state only. There is no combinational in-to-out path.
- Latency: the 13th accept at edge N gives out_valid = 1 and all buses stable from edge N through the handoff edge.
- Minimum period from the first accept to the next hand's first accept is 14 cycles:
  - 13 accepts
  - 1 HOLD cycle with out_ready high
  - in_ready returns the cycle after handoff; no same-cycle accept during handoff.
- out_ready low in HOLD stalls indefinitely, and all outputs stay constant.
- Back-to-back accepts every cycle are supported. Gaps (in_valid low) pause loading without effect.
- card_cnt and out_dup update on the same edge as the accept that causes them.

## Structure
- Shared package spj_pkg:
  - card field widths, SUIT_MSB/LSB and RANK_MSB/LSB;
  - FRONT_N = 3, MID_N = 5, BACK_N = 5, NUM_CARDS = 13;
  - the FSM state enum (IDLE, LOAD, HOLD).
- The judge should also take its field constants from spj_pkg.
- One sub-module, spj_seen_tracker, holds the 64-bit bitmap.
  - Inputs: set strobe, code, clear.
  - Output: hit, combinational lookup of the current code before the set.
- The loader holds the FSM, the counter, the slot-decode write enables and the 13 row registers.

## Test plan
- Reset, then 13 consecutive accepts of codes 0,1,2,16,17,18,19,20,32,33,34,35,36 with out_ready = 1:
  - out_valid rises after the 13th edge;
  - front = 0,1,2; mid = 16..20; back = 32..36; out_dup = 0; card_cnt = 13;
  - in_ready = 1 one cycle after handoff.
- Same stream with in_valid dropped on cards 4 and 9 for 3 cycles each: identical row contents, out_valid 6 cycles later.
- Code 17 sent as card 2 and again as card 11: out_dup = 1 at HOLD. The next clean hand reports out_dup = 0.
- Hold out_ready = 0 for 10 cycles in HOLD while driving in_valid = 1 with code 63:
  - outputs unchanged; in_ready = 0; card_cnt = 13;
  - code 63 never appears in a row.
- Assert rst after 7 accepts: card_cnt = 0 and out_valid = 0. A fresh 13-card hand then loads correctly, with no residue in out_dup.
- Two hands back-to-back with out_ready tied high: the second hand's first accept occurs exactly 14 cycles after the first hand's first accept.

Source files
------------

// File: rtl/spj_pkg.sv
// rtl/spj_pkg.sv - shared card field, row size and FSM definitions for the SPJ judge
package spj_pkg;

  localparam int CARD_W    = 6;
  localparam int SUIT_MSB  = 5;
  localparam int SUIT_LSB  = 4;
  localparam int RANK_MSB  = 3;
  localparam int RANK_LSB  = 0;
  localparam int SUIT_W    = SUIT_MSB - SUIT_LSB + 1;
  localparam int RANK_W    = RANK_MSB - RANK_LSB + 1;
  localparam int NUM_CODES = 1 << CARD_W;

  localparam int FRONT_N   = 3;
  localparam int MID_N     = 5;
  localparam int BACK_N    = 5;
  localparam int NUM_CARDS = FRONT_N + MID_N + BACK_N;
  localparam int MID_BASE  = FRONT_N;
  localparam int BACK_BASE = FRONT_N + MID_N;
  localparam int CNT_W     = 4;

  typedef logic [CARD_W-1:0] card_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic [RANK_W-1:0] card_rank(input card_t c);
    return c[RANK_MSB:RANK_LSB];
  endfunction

  function automatic logic [SUIT_W-1:0] card_suit(input card_t c);
    return c[SUIT_MSB:SUIT_LSB];
  endfunction

endpackage

// File: rtl/spj_seen_tracker.sv
// rtl/spj_seen_tracker.sv - per-hand bitmap of card codes already accepted
module spj_seen_tracker
  import spj_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  set,
  input  card_t code,
  input  logic  clear,
  output logic  hit
);

  logic [NUM_CODES-1:0] bits_q;
  logic [NUM_CODES-1:0] bits_d;

  // hit reflects the bitmap before this cycle's set lands
  always_comb begin
    bits_d = bits_q;
    hit    = bits_q[code];
    if (clear) begin
      bits_d = '0;
    end else if (set) begin
      bits_d[code] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
    end else begin
      bits_q <= bits_d;
    end
  end

endmodule

// File: rtl/spj_hand_loader.sv
// rtl/spj_hand_loader.sv - serial card intake assembling a 13-card hand for the judge
module spj_hand_loader
  import spj_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [5:0]       in_card,
  output logic             in_ready,
  output logic [5:0]       out_front1,
  output logic [5:0]       out_front2,
  output logic [5:0]       out_front3,
  output logic [5:0]       out_mid1,
  output logic [5:0]       out_mid2,
  output logic [5:0]       out_mid3,
  output logic [5:0]       out_mid4,
  output logic [5:0]       out_mid5,
  output logic [5:0]       out_back1,
  output logic [5:0]       out_back2,
  output logic [5:0]       out_back3,
  output logic [5:0]       out_back4,
  output logic [5:0]       out_back5,
  output logic             out_dup,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] card_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             dup_q, dup_d;
  card_t            rows_q [NUM_CARDS];
  card_t            rows_d [NUM_CARDS];
  logic [NUM_CARDS-1:0] slot_wen;

  logic accept;
  logic handoff;
  logic seen_hit;

  assign accept  = in_valid && in_ready_q;
  assign handoff = out_valid_q && out_ready;

  spj_seen_tracker u_seen (
    .clk   (clk),
    .rst   (rst),
    .set   (accept),
    .code  (in_card),
    .clear (handoff),
    .hit   (seen_hit)
  );

  // The running count doubles as the slot index of the next card
  always_comb begin
    for (int i = 0; i < NUM_CARDS; i++) begin
      slot_wen[i] = accept && (cnt_q == CNT_W'(i));
      rows_d[i]   = slot_wen[i] ? in_card : rows_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    dup_d       = dup_q;
    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          dup_d = dup_q | seen_hit;
          if (cnt_q == CNT_W'(NUM_CARDS - 1)) begin
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      HOLD: begin
        if (handoff) begin
          state_d     = IDLE;
          cnt_d       = '0;
          dup_d       = 1'b0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = '0;
        dup_d       = 1'b0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dup_q       <= 1'b0;
      for (int i = 0; i < NUM_CARDS; i++) begin
        rows_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      dup_q       <= dup_d;
      for (int i = 0; i < NUM_CARDS; i++) begin
        rows_q[i] <= rows_d[i];
      end
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_dup    = dup_q;
  assign card_cnt   = cnt_q;

  assign out_front1 = rows_q[0];
  assign out_front2 = rows_q[1];
  assign out_front3 = rows_q[2];
  assign out_mid1   = rows_q[MID_BASE + 0];
  assign out_mid2   = rows_q[MID_BASE + 1];
  assign out_mid3   = rows_q[MID_BASE + 2];
  assign out_mid4   = rows_q[MID_BASE + 3];
  assign out_mid5   = rows_q[MID_BASE + 4];
  assign out_back1  = rows_q[BACK_BASE + 0];
  assign out_back2  = rows_q[BACK_BASE + 1];
  assign out_back3  = rows_q[BACK_BASE + 2];
  assign out_back4  = rows_q[BACK_BASE + 3];
  assign out_back5  = rows_q[BACK_BASE + 4];

endmodule
